// File: rtl/syndrome_accumulator.sv
// Streaming S0/S1/S2 syndrome generator for RS(39,36) over GF(2^8).
// Horner accumulation per beat; registered syndromes behind a valid/ready port.
module syndrome_accumulator #(
  parameter int N_SYM = 39,
  parameter int SYM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             In_valid_in,
  output logic             In_ready_out,
  input  logic [SYM_W-1:0] In_symbol_in,
  input  logic             In_last_in,
  output logic             Out_valid_out,
  input  logic             Out_ready_in,
  output logic [SYM_W-1:0] Syndrome0_out,
  output logic [SYM_W-1:0] Syndrome1_out,
  output logic [SYM_W-1:0] Syndrome2_out,
  output logic             Frame_err_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [5:0] LAST_CNT = 6'(N_SYM - 1);

  function automatic logic [SYM_W-1:0] xtime(
    input logic [SYM_W-1:0] x
  );
    return {x[SYM_W-2:0], 1'b0} ^ (x[SYM_W-1] ? 8'h5F : 8'h00);
  endfunction

  state_t r_state;
  state_t w_next;

  logic [5:0]       r_cnt;
  logic [SYM_W-1:0] r_p0, r_p1, r_p2;
  logic [SYM_W-1:0] r_a0, r_a1, r_a2;
  logic [SYM_W-1:0] r_s0, r_s1, r_s2;
  logic             r_ferr;

  logic [SYM_W-1:0] w_p0, w_p1, w_p2;
  logic [SYM_W-1:0] w_a0, w_a1, w_a2;
  logic             w_fire;
  logic             w_term;
  logic             w_drain;

  assign w_fire  = In_valid_in && In_ready_out;
  assign w_term  = w_fire && (In_last_in || r_cnt == LAST_CNT);
  assign w_drain = (r_state == S_DONE) && Out_ready_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_fire) w_next = w_term ? S_DONE : S_ACCUM;
      end
      S_ACCUM: begin
        if (w_term) w_next = S_DONE;
      end
      S_DONE: begin
        if (Out_ready_in) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    In_ready_out  = (r_state != S_DONE);
    Out_valid_out = (r_state == S_DONE);
  end

  // Beat decode: c38, c37, c36 land in the parity holds, data runs Horner.
  always_comb begin
    w_p0 = r_p0;
    w_p1 = r_p1;
    w_p2 = r_p2;
    w_a0 = r_a0;
    w_a1 = r_a1;
    w_a2 = r_a2;
    if (w_fire) begin
      unique case (1'b1)
        (r_state == S_IDLE): w_p2 = In_symbol_in;
        (r_cnt == 6'd1):     w_p1 = In_symbol_in;
        (r_cnt == 6'd2):     w_p0 = In_symbol_in;
        default: begin
          w_a0 = r_a0 ^ In_symbol_in;
          w_a1 = xtime(r_a1) ^ In_symbol_in;
          w_a2 = xtime(xtime(r_a2)) ^ In_symbol_in;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_p0   <= '0;
      r_p1   <= '0;
      r_p2   <= '0;
      r_a0   <= '0;
      r_a1   <= '0;
      r_a2   <= '0;
      r_s0   <= '0;
      r_s1   <= '0;
      r_s2   <= '0;
      r_ferr <= 1'b0;
    end else if (w_drain) begin
      r_cnt  <= '0;
      r_p0   <= '0;
      r_p1   <= '0;
      r_p2   <= '0;
      r_a0   <= '0;
      r_a1   <= '0;
      r_a2   <= '0;
      r_s0   <= '0;
      r_s1   <= '0;
      r_s2   <= '0;
      r_ferr <= 1'b0;
    end else if (w_fire) begin
      r_cnt <= r_cnt + 6'd1;
      r_p0  <= w_p0;
      r_p1  <= w_p1;
      r_p2  <= w_p2;
      r_a0  <= w_a0;
      r_a1  <= w_a1;
      r_a2  <= w_a2;
      if (w_term) begin
        r_s0   <= w_a0 ^ w_p0;
        r_s1   <= w_a1 ^ w_p1;
        r_s2   <= w_a2 ^ w_p2;
        r_ferr <= !(In_last_in && r_cnt == LAST_CNT);
      end
    end
  end

  assign Syndrome0_out = r_s0;
  assign Syndrome1_out = r_s1;
  assign Syndrome2_out = r_s2;
  assign Frame_err_out = r_ferr;

endmodule
